// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding and word geometry.
package prog_mem_loader_pkg;

  localparam int unsigned BytesPerWord = 4;
  // Must match the depth parameter of the program memory read by the fetch stage.
  localparam int unsigned AddrWDefault = 10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/prog_mem_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word using a 2-bit lane counter.
module prog_mem_loader_byte_packer
  import prog_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic        word_full,
  output logic [31:0] word
);

  localparam logic [1:0] LastLane = 2'(BytesPerWord - 1);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
    end else if (load) begin
      lane_d = lane_q + 2'd1;
      word_d[{lane_q, 3'b000} +: 8] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  // Full word is visible in the same cycle as the last-lane accept so the top can latch it.
  assign word_full = load && !clear && (lane_q == LastLane);
  assign word      = word_d;

endmodule

// File: rtl/prog_mem_loader.sv
// Streams bytes into program memory as 32-bit words while holding the core in reset.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_q, idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       packed_word;
  logic              start_ok, accept, word_full, last_word;

  assign start_ok  = (state_q == StIdle) && start_i;
  assign accept    = byte_valid_i && byte_ready_o;
  assign last_word = (idx_q + (ADDR_W + 1)'(1)) == num_q;

  prog_mem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .load      (accept),
    .data      (byte_data_i),
    .word_full (word_full),
    .word      (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? StDone : StLoad;
        end
      end
      StLoad:  if (word_full) state_d = StWrite;
      StWrite: state_d = last_word ? StDone : StLoad;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // idx_q is one bit wider than the address so a full-depth load never wraps back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (start_ok) begin
        num_q <= (num_words_i > MaxWords) ? MaxWords : num_words_i;
        idx_q <= '0;
      end
      if (state_q == StLoad && word_full) begin
        addr_q  <= idx_q[ADDR_W-1:0];
        wdata_q <= packed_word;
      end
      if (state_q == StWrite) begin
        idx_q <= idx_q + (ADDR_W + 1)'(1);
      end
    end
  end

  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    core_rst_n_o = 1'b1;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        byte_ready_o = 1'b1;
        core_rst_n_o = 1'b0;
        busy_o       = 1'b1;
      end
      StWrite: begin
        mem_we_o     = 1'b1;
        core_rst_n_o = 1'b0;
        busy_o       = 1'b1;
      end
      StDone: begin
        done_o       = 1'b1;
        core_rst_n_o = 1'b0;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: a full-size instance and a 4-word instance.
module tb_prog_mem_loader;

  localparam int AW = 10;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, bv = 1'b0;
  logic [AW:0]   num = '0;
  logic [7:0]    bd = '0;
  logic          ready, we, core_rst_n, busy, done;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  logic          s_start = 1'b0, s_bv = 1'b0;
  logic [SW:0]   s_num = '0;
  logic [7:0]    s_bd = '0;
  logic          s_ready, s_we, s_core_rst_n, s_busy, s_done;
  logic [SW-1:0] s_addr;
  logic [31:0]   s_wdata;

  prog_mem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_words_i(num),
    .byte_valid_i(bv), .byte_data_i(bd), .byte_ready_o(ready), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(wdata), .core_rst_n_o(core_rst_n),
    .busy_o(busy), .done_o(done)
  );

  prog_mem_loader #(.ADDR_W(SW)) dut_small (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .num_words_i(s_num),
    .byte_valid_i(s_bv), .byte_data_i(s_bd), .byte_ready_o(s_ready), .mem_we_o(s_we),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .core_rst_n_o(s_core_rst_n),
    .busy_o(s_busy), .done_o(s_done)
  );

  int checks = 0, failures = 0;
  int cyc = 0, we_cyc = -1, done_cyc = -1, bad_hold = 0, ready_cnt = 0;
  logic [AW+31:0] exp_q[$], obs_q[$];
  logic [SW+31:0] sexp_q[$], sobs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      obs_q.push_back({addr, wdata});
      we_cyc = cyc;
    end
    if (s_we) sobs_q.push_back({s_addr, s_wdata});
    if (done) done_cyc = cyc;
    if (busy && core_rst_n) bad_hold++;
    if (ready) ready_cnt++;
  end

  task automatic send_byte(input bit sm, input logic [7:0] b);
    int t = 0;
    if (sm) begin s_bv = 1'b1; s_bd = b; end
    else begin bv = 1'b1; bd = b; end
    while (!(sm ? s_ready : ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_byte: byte_ready_o stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    if (sm) s_bv = 1'b0;
    else bv = 1'b0;
  endtask

  task automatic send_word(input bit sm, input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(sm, w[8*i +: 8]);
    end
  endtask

  task automatic start_load(input bit sm, input int n, output int c0);
    c0 = cyc;
    if (sm) begin s_start = 1'b1; s_num = n[SW:0]; end
    else begin start = 1'b1; num = n[AW:0]; end
    @(negedge clk);
    s_start = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit sm, input int limit);
    int t = 0;
    while ((sm ? s_busy : busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy_o still 1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    bv = 1'b1;
    bd = 8'hAA;
    #100 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, we, addr, wdata, core_rst_n, busy, done} !== {2'b00, 42'd0, 3'b100}) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b, required 0 0 0 0 1 0 0",
               ready, we, addr, wdata, core_rst_n, busy, done);
    end
    repeat (5) @(negedge clk);
    bv = 1'b0;
    checks++;
    if (ready_cnt != 0 || busy !== 1'b0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL idle_no_accept: got ready cycles=%0d busy=%b writes=%0d, required 0 0 0",
               ready_cnt, busy, obs_q.size());
    end
  endtask

  task automatic test_single();
    int c0;
    logic [AW+31:0] e, o;
    bad_hold = 0;
    exp_q.push_back({AW'(0), 32'h00000513});
    start_load(0, 1, c0);
    checks++;
    if (core_rst_n !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_hold: got core_rst_n=%b busy=%b, required 0 1", core_rst_n, busy);
    end
    send_word(0, 32'h00000513, 0);
    wait_idle(0, 20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL single_write: got no write, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL single_write: got %h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL single_extra: got %0d extra writes, required 0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if (done_cyc != we_cyc + 1) begin
      failures++;
      $display("FAIL single_done_timing: done at cycle %0d, required %0d", done_cyc, we_cyc + 1);
    end
    checks++;
    if (bad_hold != 0 || core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL single_core_rst: got released-while-busy=%0d final=%b, required 0 1",
               bad_hold, core_rst_n);
    end
  endtask

  task automatic test_words(input int max_gap, input bit timed);
    int c0;
    logic [31:0] w[4];
    logic [AW+31:0] e, o;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      exp_q.push_back({AW'(i), w[i]});
    end
    start_load(0, 4, c0);
    for (int i = 0; i < 4; i++) send_word(0, w[i], max_gap);
    wait_idle(0, 20);
    if (timed) begin
      checks++;
      if (cyc - c0 != 22) begin
        failures++;
        $display("FAIL b2b_cycles: got %0d cycles start->idle, required 22", cyc - c0);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL words_write: got no write, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL words_write: got %h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL words_extra: got %0d extra writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_zero();
    int c0, r0;
    r0 = ready_cnt;
    start_load(0, 0, c0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: got done_o=%b the cycle after start, required 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ready_cnt != r0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL zero_quiet: got done=%b busy=%b ready cycles=%0d writes=%0d, required 0 0 0 0",
               done, busy, ready_cnt - r0, obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [AW+31:0] e, o;
    exp_q.push_back({AW'(0), 32'hCAFE_F00D});
    start_load(0, 3, c0);
    send_word(0, 32'hCAFE_F00D, 0);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, we, addr, wdata, core_rst_n, busy, done} !== {2'b00, 42'd0, 3'b100}) begin
      failures++;
      $display("FAIL mid_reset_values: got rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b, required 0 0 0 0 1 0 0",
               ready, we, addr, wdata, core_rst_n, busy, done);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({AW'(0), 32'h0BAD_BEEF});
    start_load(0, 1, c0);
    send_word(0, 32'h0BAD_BEEF, 1);
    wait_idle(0, 20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL mid_write: got no write, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL mid_write: got %h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL mid_extra: got %0d extra writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_ignore_start();
    int c0;
    logic [AW+31:0] e, o;
    exp_q.push_back({AW'(0), 32'h1234_5678});
    exp_q.push_back({AW'(1), 32'h9ABC_DEF0});
    start_load(0, 2, c0);
    send_word(0, 32'h1234_5678, 0);
    start = 1'b1;
    num = 11'd5;
    @(negedge clk);
    start = 1'b0;
    send_word(0, 32'h9ABC_DEF0, 2);
    wait_idle(0, 20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL ignore_write: got no write, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL ignore_write: got %h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL ignore_extra: got %0d extra writes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  // n=7 exceeds the 4-word depth and must saturate to 4.
  task automatic test_small_depth(input int n);
    int c0;
    logic [31:0] w;
    logic [SW+31:0] e, o;
    start_load(1, n, c0);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      sexp_q.push_back({SW'(i), w});
      send_word(1, w, 1);
    end
    wait_idle(1, 20);
    while (sexp_q.size() != 0) begin
      e = sexp_q.pop_front();
      checks++;
      if (sobs_q.size() == 0) begin
        failures++;
        $display("FAIL small_write n=%0d: got no write, required %h", n, e);
      end else begin
        o = sobs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL small_write n=%0d: got %h, required %h", n, o, e);
        end
      end
    end
    checks++;
    if (sobs_q.size() != 0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL small_extra n=%0d: got %0d extra writes busy=%b, required 0 0",
               n, sobs_q.size(), s_busy);
      sobs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_words(3, 1'b0);
    test_words(0, 1'b1);
    test_zero();
    test_reset_mid();
    test_ignore_start();
    test_small_depth(4);
    test_small_depth(7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500us, required completion");
    $fatal(1, "timeout");
  end

endmodule
